sa_pe_pipelined: RTL and testbench

- Parametrised output-stationary systolic processing element; successor to the fixed 32-bit PE.
- Forwards A east and B south with valid/last tags and runs a pipelined multiply into a tile accumulator.
- Shifts completed results out over a per-column result chain (C_in → C_out).
- Tiled into an R×C array by the array top; a drain controller drives SHIFT_EN.

---
 rtl/sa_pkg.sv | 30 +++
 rtl/sa_pe_pipelined_mul.sv | 72 +++++++
 rtl/sa_pe_pipelined.sv | 218 +++++++++++++++++++++
 tb/tb_sa_pe_pipelined.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic PE.
//   pe_state_e  : accumulator FSM state (IDLE, ACCUM)
//   MUL_LAT_MAX : deepest supported multiplier pipeline
//   ext_prod()  : sign/zero-extends a product up to EXT_W bits
package sa_pkg;

  typedef enum logic {IDLE, ACCUM} pe_state_e;

  localparam int unsigned MUL_LAT_MAX = 4;

  // Widest product/accumulator the helper handles; callers truncate to ACC_W.
  localparam int unsigned EXT_W     = 128;
  localparam int unsigned EXT_IDX_W = $clog2(EXT_W);

  // prod must be zero above prod_w; the upper bits are filled with the sign
  // bit when is_signed is set.
  function automatic logic [EXT_W-1:0] ext_prod(input logic [EXT_W-1:0] prod,
                                                input int unsigned      prod_w,
                                                input logic             is_signed);
    logic [EXT_W-1:0]     ones;
    logic [EXT_IDX_W-1:0] msb;
    ones = '1;
    msb  = EXT_IDX_W'(prod_w - 1);
    if (is_signed && prod[msb]) begin
      return prod | (ones << prod_w);
    end
    return prod;
  endfunction

endpackage

// File: rtl/sa_pe_pipelined_mul.sv
// sa_mul_pipe: MUL_LAT-stage multiplier carrying valid and last tags.
//   clk_i, rst_i (sync, active-high), en_i (advance)
//   a_i, b_i, vld_i, last_i : operands and tags at issue
//   prod_o, vld_o, last_o   : product and tags MUL_LAT cycles later
//   busy_o                  : any stage holds a valid product
module sa_mul_pipe
  import sa_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter bit          SIGNED  = 1'b1,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  input  logic                  vld_i,
  input  logic                  last_i,
  output logic [2*DATA_W-1:0]   prod_o,
  output logic                  vld_o,
  output logic                  last_o,
  output logic                  busy_o
);

  localparam int unsigned Lat = (MUL_LAT < 1) ? 1 :
                                (MUL_LAT > MUL_LAT_MAX) ? MUL_LAT_MAX : MUL_LAT;
  localparam int unsigned PW  = 2 * DATA_W;

  logic [PW-1:0]          prod_c;
  logic [PW-1:0]          a_ext, b_ext;
  logic [Lat-1:0][PW-1:0] prod_q;
  logic [Lat-1:0]         vld_q, last_q;

  // Extending both operands to PW bits makes the low PW bits of an unsigned
  // multiply equal the signed product when SIGNED is set.
  assign a_ext  = {{DATA_W{SIGNED & a_i[DATA_W-1]}}, a_i};
  assign b_ext  = {{DATA_W{SIGNED & b_i[DATA_W-1]}}, b_i};
  assign prod_c = a_ext * b_ext;

  if (Lat == 1) begin : g_one
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        prod_q <= '0;
        vld_q  <= '0;
        last_q <= '0;
      end else if (en_i) begin
        prod_q <= prod_c;
        vld_q  <= vld_i;
        last_q <= last_i;
      end
    end
  end else begin : g_multi
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        prod_q <= '0;
        vld_q  <= '0;
        last_q <= '0;
      end else if (en_i) begin
        prod_q <= {prod_q[Lat-2:0], prod_c};
        vld_q  <= {vld_q[Lat-2:0], vld_i};
        last_q <= {last_q[Lat-2:0], last_i};
      end
    end
  end

  assign prod_o = prod_q[Lat-1];
  assign vld_o  = vld_q[Lat-1];
  assign last_o = last_q[Lat-1];
  assign busy_o = |vld_q;

endmodule

// File: rtl/sa_pe_pipelined.sv
// sa_pe_pipelined: output-stationary systolic PE with pipelined MAC.
//   CLK, RST (sync, active-high, overrides EN), EN (global advance)
//   A_* / B_*      : operands in, registered copies forwarded east / south
//   SHIFT_EN, C_*  : per-column result chain (C_in -> C_out)
//   BUSY           : partial sum, multiplier pipeline or pending result live
//   ERR            : sticky, operand mismatch or dropped result
//   SAT            : sticky saturation flag, only with PE_SAT_EN defined
// Build option PE_SAT_EN: saturating accumulator instead of wrap-around.
module sa_pe_pipelined
  import sa_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ACC_W   = 64,
  parameter bit          SIGNED  = 1'b1,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [DATA_W-1:0] A_in,
  input  logic              A_vld_in,
  input  logic              A_last_in,
  input  logic [DATA_W-1:0] B_in,
  input  logic              B_vld_in,
  output logic [DATA_W-1:0] A_out,
  output logic              A_vld_out,
  output logic              A_last_out,
  output logic [DATA_W-1:0] B_out,
  output logic              B_vld_out,
  input  logic              SHIFT_EN,
  input  logic [ACC_W-1:0]  C_in,
  input  logic              C_vld_in,
  output logic [ACC_W-1:0]  C_out,
  output logic              C_vld_out,
  output logic              BUSY,
`ifdef PE_SAT_EN
  output logic              SAT,
`endif
  output logic              ERR
);

  logic [DATA_W-1:0]   a_q, b_q;
  logic                a_vld_q, a_last_q, b_vld_q;
  logic [2*DATA_W-1:0] mul_prod;
  logic                mul_vld, mul_last, mul_busy;
  logic [EXT_W-1:0]    prod_wide;
  logic [ACC_W-1:0]    prod_ext, base, sum_val, res;
  logic                res_vld, drop;
  pe_state_e           state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d, c_q, c_d, pend_q, pend_d;
  logic                cv_q, cv_d, pv_q, pv_d, err_q, err_d;
`ifdef PE_SAT_EN
  logic [ACC_W:0]      sum_full;
  logic                ovf, sat_q, sat_d;
`endif

  // Forwarding: data regs load only with their valid, tags load every cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q      <= '0;
      b_q      <= '0;
      a_vld_q  <= 1'b0;
      a_last_q <= 1'b0;
      b_vld_q  <= 1'b0;
    end else if (EN) begin
      if (A_vld_in) a_q <= A_in;
      if (B_vld_in) b_q <= B_in;
      a_vld_q  <= A_vld_in;
      a_last_q <= A_last_in;
      b_vld_q  <= B_vld_in;
    end
  end

  sa_mul_pipe #(
    .DATA_W (DATA_W),
    .SIGNED (SIGNED),
    .MUL_LAT(MUL_LAT)
  ) u_mul (
    .clk_i (CLK),
    .rst_i (RST),
    .en_i  (EN),
    .a_i   (A_in),
    .b_i   (B_in),
    .vld_i (A_vld_in & B_vld_in),
    .last_i(A_last_in),
    .prod_o(mul_prod),
    .vld_o (mul_vld),
    .last_o(mul_last),
    .busy_o(mul_busy)
  );

  always_comb begin
    prod_wide                 = '0;
    prod_wide[2*DATA_W-1:0]   = mul_prod;
  end
  assign prod_ext = ACC_W'(ext_prod(prod_wide, 2 * DATA_W, SIGNED));

  // ACC is held at zero in IDLE, so both states add onto the same base.
  assign base = (state_q == ACCUM) ? acc_q : '0;

`ifdef PE_SAT_EN
  always_comb begin
    sum_full = SIGNED ? ({base[ACC_W-1], base} + {prod_ext[ACC_W-1], prod_ext})
                      : ({1'b0, base} + {1'b0, prod_ext});
    ovf      = SIGNED ? (sum_full[ACC_W] ^ sum_full[ACC_W-1]) : sum_full[ACC_W];
    sum_val  = sum_full[ACC_W-1:0];
    if (ovf) begin
      if (!SIGNED)               sum_val = '1;
      else if (sum_full[ACC_W])  sum_val = {1'b1, {(ACC_W-1){1'b0}}};
      else                       sum_val = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum_val = base + prod_ext;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    res_vld = 1'b0;
    res     = '0;
    if (mul_vld) begin
      if (mul_last) begin
        res_vld = 1'b1;
        res     = sum_val;
        acc_d   = '0;
        state_d = IDLE;
      end else begin
        acc_d   = sum_val;
        state_d = ACCUM;
      end
    end
  end

  // Result placement: a chain shift always wins the C_out slot; the pending
  // register absorbs one result and refills C_out once the slot is free.
  always_comb begin
    c_d    = c_q;
    cv_d   = cv_q;
    pend_d = pend_q;
    pv_d   = pv_q;
    drop   = 1'b0;
    if (SHIFT_EN) begin
      c_d  = C_in;
      cv_d = C_vld_in;
      if (res_vld) begin
        if (pv_q) begin
          drop = 1'b1;
        end else begin
          pend_d = res;
          pv_d   = 1'b1;
        end
      end
    end else if (!cv_q) begin
      if (pv_q) begin
        c_d  = pend_q;
        cv_d = 1'b1;
        if (res_vld) pend_d = res;
        else         pv_d   = 1'b0;
      end else if (res_vld) begin
        c_d  = res;
        cv_d = 1'b1;
      end
    end else if (res_vld) begin
      if (pv_q) begin
        drop = 1'b1;
      end else begin
        pend_d = res;
        pv_d   = 1'b1;
      end
    end
    err_d = err_q | (A_vld_in ^ B_vld_in) | drop;
  end

`ifdef PE_SAT_EN
  assign sat_d = sat_q | (mul_vld & ovf);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      acc_q   <= '0;
      c_q     <= '0;
      cv_q    <= 1'b0;
      pend_q  <= '0;
      pv_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef PE_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else if (EN) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cv_q    <= cv_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      err_q   <= err_d;
`ifdef PE_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign A_out      = a_q;
  assign A_vld_out  = a_vld_q;
  assign A_last_out = a_last_q;
  assign B_out      = b_q;
  assign B_vld_out  = b_vld_q;
  assign C_out      = c_q;
  assign C_vld_out  = cv_q;
  assign BUSY       = (state_q == ACCUM) | mul_busy | pv_q;
  assign ERR        = err_q;
`ifdef PE_SAT_EN
  assign SAT        = sat_q;
`endif

endmodule

// File: tb/tb_sa_pe_pipelined.sv
module tb_sa_pe_pipelined;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 18;
  localparam int unsigned ML = 2;
  localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (AW - 1));
  localparam longint MASK = (longint'(1) << AW) - 1;

  logic          CLK, RST, EN;
  logic [DW-1:0] A_in, B_in, A_out, B_out;
  logic          A_vld_in, A_last_in, B_vld_in, A_vld_out, A_last_out, B_vld_out;
  logic          SHIFT_EN, C_vld_in, C_vld_out, BUSY, ERR;
  logic [AW-1:0] C_in, C_out;
`ifdef PE_SAT_EN
  logic          SAT, u_sat;
`endif

  // Second, unsigned instance for the 16-bit wrap/saturate case.
  logic          u_en, u_av, u_last, u_bv, u_shift, u_cvin;
  logic [7:0]    u_a, u_b, u_aout, u_bout;
  logic          u_avout, u_lastout, u_bvout, u_cvld, u_busy, u_err;
  logic [15:0]   u_cin, u_cout;

  int n_tests = 0;
  int n_fail  = 0;

  sa_pe_pipelined #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1'b1), .MUL_LAT(ML)) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .A_in(A_in), .A_vld_in(A_vld_in), .A_last_in(A_last_in),
    .B_in(B_in), .B_vld_in(B_vld_in),
    .A_out(A_out), .A_vld_out(A_vld_out), .A_last_out(A_last_out),
    .B_out(B_out), .B_vld_out(B_vld_out),
    .SHIFT_EN(SHIFT_EN), .C_in(C_in), .C_vld_in(C_vld_in),
    .C_out(C_out), .C_vld_out(C_vld_out), .BUSY(BUSY),
`ifdef PE_SAT_EN
    .SAT(SAT),
`endif
    .ERR(ERR)
  );

  sa_pe_pipelined #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b0), .MUL_LAT(1)) dut_u (
    .CLK(CLK), .RST(RST), .EN(u_en),
    .A_in(u_a), .A_vld_in(u_av), .A_last_in(u_last),
    .B_in(u_b), .B_vld_in(u_bv),
    .A_out(u_aout), .A_vld_out(u_avout), .A_last_out(u_lastout),
    .B_out(u_bout), .B_vld_out(u_bvout),
    .SHIFT_EN(u_shift), .C_in(u_cin), .C_vld_in(u_cvin),
    .C_out(u_cout), .C_vld_out(u_cvld), .BUSY(u_busy),
`ifdef PE_SAT_EN
    .SAT(u_sat),
`endif
    .ERR(u_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- behavioural reference model ----------------
  typedef struct {
    longint due;
    longint p;
    bit     last;
  } flight_t;

  flight_t       q[$];
  longint        cnt, m_acc, m_c, m_pend;
  bit            m_open, m_cv, m_pv, m_err, m_sat;
  logic [DW-1:0] m_a, m_b;
  bit            m_av, m_al, m_bv;

  function automatic longint smul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW-1:0] sa, sb;
    sa = a;
    sb = b;
    return longint'(sa) * longint'(sb);
  endfunction

  task automatic model_reset();
    q.delete();
    cnt = 0; m_acc = 0; m_c = 0; m_pend = 0;
    m_open = 0; m_cv = 0; m_pv = 0; m_err = 0; m_sat = 0;
    m_a = '0; m_b = '0; m_av = 0; m_al = 0; m_bv = 0;
  endtask

  task automatic model_step();
    longint p, exact, s, res;
    bit     have, pl, rv;
    if (RST) begin
      model_reset();
      return;
    end
    if (!EN) return;
    cnt++;
    have = 0; rv = 0; p = 0; pl = 0; res = 0;
    if (q.size() > 0 && q[0].due == cnt) begin
      have = 1; p = q[0].p; pl = q[0].last;
      q.delete(0);
    end
    if (A_vld_in && B_vld_in) q.push_back('{cnt + ML, smul(A_in, B_in), A_last_in});
    else if (A_vld_in != B_vld_in) m_err = 1;
    if (A_vld_in) m_a = A_in;
    if (B_vld_in) m_b = B_in;
    m_av = A_vld_in; m_al = A_last_in; m_bv = B_vld_in;
    if (have) begin
      exact = m_acc + p;
`ifdef PE_SAT_EN
      if (exact > MAXV)      begin s = MAXV; m_sat = 1; end
      else if (exact < MINV) begin s = MINV; m_sat = 1; end
      else                   s = exact;
`else
      s = exact & MASK;
      if (s > MAXV) s = s - (MASK + 1);
`endif
      if (pl) begin res = s; rv = 1; m_acc = 0; m_open = 0; end
      else    begin m_acc = s; m_open = 1; end
    end
    if (SHIFT_EN) begin
      m_c = longint'(C_in); m_cv = C_vld_in;
      if (rv) begin
        if (m_pv) m_err = 1;
        else begin m_pend = res; m_pv = 1; end
      end
    end else if (!m_cv) begin
      if (m_pv) begin
        m_c = m_pend; m_cv = 1;
        if (rv) m_pend = res;
        else    m_pv = 0;
      end else if (rv) begin
        m_c = res; m_cv = 1;
      end
    end else if (rv) begin
      if (m_pv) m_err = 1;
      else begin m_pend = res; m_pv = 1; end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [AW-1:0] ec;
    ec = m_c[AW-1:0];
    check("a_out",      64'(A_out),      64'(m_a));
    check("a_vld_out",  64'(A_vld_out),  64'(m_av));
    check("a_last_out", 64'(A_last_out), 64'(m_al));
    check("b_out",      64'(B_out),      64'(m_b));
    check("b_vld_out",  64'(B_vld_out),  64'(m_bv));
    check("c_out",      64'(C_out),      64'(ec));
    check("c_vld_out",  64'(C_vld_out),  64'(m_cv));
    check("busy",       64'(BUSY),       64'(m_open | (q.size() > 0) | m_pv));
    check("err",        64'(ERR),        64'(m_err));
`ifdef PE_SAT_EN
    check("sat",        64'(SAT),        64'(m_sat));
`endif
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic idle();
    RST = 0; EN = 1; SHIFT_EN = 0; C_vld_in = 0; C_in = '0;
    A_vld_in = 0; B_vld_in = 0; A_last_in = 0;
  endtask

  task automatic pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit last);
    A_in = a; B_in = b; A_vld_in = 1; B_vld_in = 1; A_last_in = last;
  endtask

  task automatic do_reset();
    idle(); RST = 1; step(); step(); RST = 0;
  endtask

  int            n;
  logic [AW-1:0] neg5, last_cin;

  initial begin
    idle();
    RST = 1;
    u_en = 1; u_av = 0; u_bv = 0; u_last = 0; u_a = '0; u_b = '0;
    u_shift = 0; u_cin = '0; u_cvin = 0;
    A_in = '0; B_in = '0;
    model_reset();
    neg5 = '0 - AW'(5);

    // Reset state
    step(); step();
    check("rst_c_vld", 64'(C_vld_out), 64'd0);
    check("rst_busy",  64'(BUSY),      64'd0);
    RST = 0;

    // Signed tile (3,4),(-2,5),(7,-1) -> -5
    pair(8'd3, 8'd4, 0); step();
    check("fwd_a1", 64'(A_out), 64'd3);
    pair(8'hFE, 8'd5, 0); step();
    pair(8'd7, 8'hFF, 1); step();
    check("fwd_a3",    64'(A_out),      64'h07);
    check("fwd_b3",    64'(B_out),      64'hFF);
    check("fwd_last3", 64'(A_last_out), 64'd1);
    idle();
    n = 1;
    while (C_vld_out !== 1'b1 && n < 10) begin step(); n++; end
    check("tile1_latency", 64'(n),     64'(ML + 1));
    check("tile1_result",  64'(C_out), 64'(neg5));
    check("model_pin_m5",  64'(m_c[AW-1:0]), 64'(neg5));

    // Back-to-back tiles: 4 then 6, second parked in pending
    do_reset();
    for (int i = 0; i < 4; i++) begin pair(8'd1, 8'd1, i == 3); step(); end
    pair(8'd2, 8'd3, 1); step();
    idle();
    for (int i = 0; i < 4; i++) step();
    check("b2b_first",   64'(C_out),     64'd4);
    check("b2b_vld",     64'(C_vld_out), 64'd1);
    check("b2b_pending", 64'(BUSY),      64'd1);
    SHIFT_EN = 1; step();
    check("b2b_shift_vld", 64'(C_vld_out), 64'd0);
    SHIFT_EN = 0; step();
    check("b2b_second", 64'(C_out), 64'd6);
    check("b2b_busy",   64'(BUSY),  64'd0);
    check("b2b_err",    64'(ERR),   64'd0);

    // Operand mismatch: no accumulate, sticky ERR
    do_reset();
    A_in = 8'd9; A_vld_in = 1; step();
    idle();
    for (int i = 0; i < 4; i++) step();
    check("mis_err",   64'(ERR),       64'd1);
    check("mis_busy",  64'(BUSY),      64'd0);
    check("mis_c_vld", 64'(C_vld_out), 64'd0);

    // Three results while shifting: overflow drop, chain passes C_in through
    do_reset();
    SHIFT_EN = 1;
    for (int i = 0; i < 3 + ML + 2; i++) begin
      if (i < 3) pair(8'(i + 2), 8'd3, 1);
      else begin A_vld_in = 0; B_vld_in = 0; A_last_in = 0; end
      C_in = AW'($urandom); C_vld_in = 1'($urandom);
      last_cin = C_in;
      step();
      check("chain_pass", 64'(C_out), 64'(last_cin));
    end
    check("drop_err", 64'(ERR), 64'd1);

    // Reset mid-tile with EN low
    SHIFT_EN = 0; C_vld_in = 0;
    for (int i = 0; i < 3; i++) begin pair(8'd5, 8'd5, 0); step(); end
    check("mid_busy", 64'(BUSY), 64'd1);
    EN = 0; RST = 1; step();
    check("mid_rst_busy",  64'(BUSY),      64'd0);
    check("mid_rst_c",     64'(C_out),     64'd0);
    check("mid_rst_c_vld", 64'(C_vld_out), 64'd0);
    check("mid_rst_err",   64'(ERR),       64'd0);
    check("mid_rst_a",     64'(A_out),     64'd0);
    idle();
    pair(8'd2, 8'd2, 1); step();
    idle();
    n = 1;
    while (C_vld_out !== 1'b1 && n < 10) begin step(); n++; end
    check("post_rst_tile", 64'(C_out), 64'd4);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      RST      = ($urandom_range(0, 299) == 0);
      EN       = ($urandom_range(0, 9) != 0);
      SHIFT_EN = ($urandom_range(0, 2) == 0);
      C_in     = AW'($urandom);
      C_vld_in = 1'($urandom);
      A_in     = DW'($urandom);
      B_in     = DW'($urandom);
      A_last_in = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 99));
      A_vld_in = (r < 60) || (r == 98);
      B_vld_in = (r < 60) || (r == 99);
      step();
    end

    // Unsigned 16-bit accumulator: 2 x (255 x 255)
    do_reset();
    u_a = 8'hFF; u_b = 8'hFF; u_av = 1; u_bv = 1; u_last = 0; step();
    u_last = 1; step();
    u_av = 0; u_bv = 0; u_last = 0;
    n = 0;
    while (u_cvld !== 1'b1 && n < 8) begin step(); n++; end
    check("u_c_vld", 64'(u_cvld), 64'd1);
`ifdef PE_SAT_EN
    check("u_sat_result", 64'(u_cout), 64'hFFFF);
    check("u_sat_flag",   64'(u_sat),  64'd1);
`else
    check("u_wrap_result", 64'(u_cout), 64'hFC02);
`endif
    check("u_err", 64'(u_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
